// File: rtl/mem_pkg.sv
// Shared types and constants for the fetch/data memory sequencer.
// Holds the FSM state encoding, memsize codes and the idle instruction.
package mem_pkg;

    typedef enum logic [2:0] {
        FETCH,
        EXEC,
        DATA,
        COMMIT,
        HALT
    } seq_state_t;

    localparam logic [1:0] MS_NONE = 2'b00;
    localparam logic [1:0] MS_B    = 2'b01;
    localparam logic [1:0] MS_H    = 2'b10;
    localparam logic [1:0] MS_W    = 2'b11;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    function automatic logic misaligned(
        input logic [1:0] size,
        input logic [1:0] off
    );
        return (size == MS_H && off[0]) ||
               (size == MS_W && off != 2'b00);
    endfunction

endpackage

// File: rtl/mem_sequencer_if.sv
// Single-port memory bus between the sequencer and the memory.
// Request is held until ack; ack may arrive in the request's first cycle.
interface mem_sequencer_if;

    logic        mreq;
    logic        mwe;
    logic [31:0] maddr;
    logic [31:0] mwdata;
    logic [3:0]  mbe;
    logic [31:0] mrdata;
    logic        mack;

    modport master (
        output mreq, mwe, maddr, mwdata, mbe,
        input  mrdata, mack
    );

    modport slave (
        input  mreq, mwe, maddr, mwdata, mbe,
        output mrdata, mack
    );

endinterface

// File: rtl/mem_lane_align.sv
// Byte-lane placement of store data and extraction of load data.
// Purely combinational; driven by access size and address offset.
module mem_lane_align
    import mem_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  off,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [31:0] mwdata,
    output logic [3:0]  be,
    output logic [31:0] rdata
);

    logic [31:0] sh;

    always_comb begin
        sh     = rword >> {off, 3'b000};
        mwdata = wdata;
        be     = 4'b0000;
        rdata  = 32'h0;
        unique case (1'b1)
            size == MS_B: begin
                mwdata = {4{wdata[7:0]}};
                be     = 4'b0001 << off;
                rdata  = {24'h0, sh[7:0]};
            end
            size == MS_H: begin
                mwdata = {2{wdata[15:0]}};
                be     = 4'b0011 << off;
                rdata  = {16'h0, sh[15:0]};
            end
            size == MS_W: begin
                mwdata = wdata;
                be     = 4'b1111;
                rdata  = sh;
            end
            default: begin
                mwdata = wdata;
                be     = 4'b0000;
                rdata  = 32'h0;
            end
        endcase
    end

endmodule

// File: rtl/mem_sequencer.sv
// Multi-cycle sequencer sharing one memory port between fetch and load/store.
// Commits the core with a one-cycle o_cpu_en strobe per instruction.
module mem_sequencer #(
    parameter int unsigned TIMEOUT  = 255,
    parameter logic [31:0] NOP_INST = mem_pkg::NOP_INST
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [31:0] i_pc,
    input  logic        i_load,
    input  logic        i_write,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    input  logic [1:0]  i_memsize,
    output logic [31:0] o_inst,
    output logic [31:0] o_rdata,
    output logic        o_cpu_en,
    output logic        o_fault,
    mem_sequencer_if.master mem
);
    import mem_pkg::*;

    localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    seq_state_t    st, nxt;
    logic [CW-1:0] cnt;
    logic [31:0]   inst_q, rdata_q;
    logic [31:0]   lane_wdata, lane_rdata;
    logic [3:0]    lane_be;
    logic          fault_q, req, we, set_fault;
    logic          take_inst, take_data, wait_mem;

    mem_lane_align u_align (
        .size   (i_memsize),
        .off    (i_addr[1:0]),
        .wdata  (i_wdata),
        .rword  (mem.mrdata),
        .mwdata (lane_wdata),
        .be     (lane_be),
        .rdata  (lane_rdata)
    );

    always_comb begin
        nxt       = st;
        req       = 1'b0;
        we        = 1'b0;
        o_cpu_en  = 1'b0;
        set_fault = 1'b0;
        take_inst = 1'b0;
        take_data = 1'b0;
        unique case (st)
            FETCH: begin
                if (i_pc[1:0] != 2'b00) begin
                    set_fault = 1'b1;
                    nxt       = HALT;
                end else begin
                    req = 1'b1;
                    if (mem.mack) begin
                        take_inst = 1'b1;
                        nxt       = EXEC;
                    end
                end
            end
            EXEC: begin
                if (!i_load && !i_write) begin
                    o_cpu_en = 1'b1;
                    nxt      = FETCH;
                end else if (misaligned(i_memsize, i_addr[1:0])) begin
                    set_fault = 1'b1;
                    nxt       = HALT;
                end else begin
                    nxt = DATA;
                end
            end
            DATA: begin
                req = 1'b1;
                // A load wins when the core illegally asks for both.
                we  = i_write && !i_load;
                if (mem.mack) begin
                    take_data = i_load;
                    nxt       = COMMIT;
                end
            end
            COMMIT: begin
                o_cpu_en = 1'b1;
                nxt      = FETCH;
            end
            HALT:    nxt = HALT;
            default: nxt = HALT;
        endcase
        if (req && !mem.mack && cnt == CW'(TIMEOUT - 1)) begin
            set_fault = 1'b1;
            nxt       = HALT;
        end
    end

    // Reset gates the request combinationally so an abandoned access drops at once.
    assign mem.mreq   = req && !i_rst;
    assign mem.mwe    = we && !i_rst;
    assign mem.mbe    = we ? lane_be : 4'b0000;
    assign mem.mwdata = lane_wdata;
    assign mem.maddr  = (st == DATA) ? {i_addr[31:2], 2'b00}
                                     : {i_pc[31:2], 2'b00};
    assign wait_mem   = mem.mreq && !mem.mack;

    assign o_inst  = (st == HALT) ? NOP_INST : inst_q;
    assign o_rdata = rdata_q;
    assign o_fault = fault_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            st      <= FETCH;
            inst_q  <= NOP_INST;
            rdata_q <= 32'h0;
            fault_q <= 1'b0;
            cnt     <= '0;
        end else begin
            st <= nxt;
            if (take_inst) inst_q <= mem.mrdata;
            if (take_data) rdata_q <= lane_rdata;
            if (set_fault) fault_q <= 1'b1;
            cnt <= wait_mem ? cnt + CW'(1) : '0;
        end
    end

endmodule
